// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate operations.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } mdu_state_t;

  localparam int unsigned MUL_LAT_DEFAULT   = 4;
  localparam int unsigned DIV_ITERS_DEFAULT = 32;

  function automatic logic is_mul_op(input mdu_op_t op);
    case (op)
      MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input mdu_op_t op);
    case (op)
      MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_div32.sv
// Unsigned radix-2 restoring divider; first iteration runs on the start cycle
// so the result is ready after exactly ITERS clock edges.
module mdu_div32 #(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, div_q;
  logic [31:0] src_rem, src_quo, src_div, rem_n, quo_n;
  logic [32:0] shifted, diff;

  always_comb begin
    src_rem = start_i ? '0  : rem_q;
    src_quo = start_i ? a_i : quo_q;
    src_div = start_i ? b_i : div_q;
    shifted = {src_rem, src_quo[31]};
    // Partial remainder stays below the divisor, so bit 32 of diff is the borrow.
    diff    = shifted - {1'b0, src_div};
    rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
    quo_n   = {src_quo[30:0], ~diff[32]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (abort_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      div_q <= b_i;
      cnt_q <= 6'(ITERS - 1);
    end else if (cnt_q != '0) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 6'd1;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Execute-stage HI/LO owner: sequences multiply and divide, stalls the pipe
// until commit. MDU_MADD_EN enables the accumulate ops (MADD/MSUB family).
module hilo_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT   = MUL_LAT_DEFAULT,
  parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  mdu_op_t     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_t  state_q, state_d;
  mdu_op_t     op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic        div_start, div_abort, div_busy, div_signed;
  logic [31:0] div_quo, div_rem, a_mag, b_mag;
  logic        mul_signed;
  logic [63:0] product, mul_result;

  always_comb begin
    div_signed = (op_i == MDU_DIV);
    a_mag      = (div_signed && a_i[31]) ? (~a_i + 32'd1) : a_i;
    b_mag      = (div_signed && b_i[31]) ? (~b_i + 32'd1) : b_i;
  end

  mdu_div32 #(
    .ITERS(DIV_ITERS)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .a_i        (a_mag),
    .b_i        (b_mag),
    .busy_o     (div_busy),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // Sign-extending to 64 bits makes the truncated product correct for both signednesses.
  always_comb begin
    mul_signed = is_signed_op(op_q);
    product    = {{32{mul_signed & a_q[31]}}, a_q} * {{32{mul_signed & b_q[31]}}, b_q};
`ifdef MDU_MADD_EN
    case (op_q)
      MDU_MADD, MDU_MADDU: mul_result = {hi_q, lo_q} + product;
      MDU_MSUB, MDU_MSUBU: mul_result = {hi_q, lo_q} - product;
      default:             mul_result = product;
    endcase
`else
    mul_result = product;
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_start = 1'b0;
    div_abort = 1'b0;
    stall_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (op_i == MDU_MTHI) begin
            hi_d = a_i;
          end else if (op_i == MDU_MTLO) begin
            lo_d = a_i;
          end else if (is_mul_op(op_i)) begin
            stall_o = 1'b1;
            a_d     = a_i;
            b_d     = b_i;
            op_d    = op_i;
            cnt_d   = '0;
            state_d = MUL;
          end else if (op_i == MDU_DIV || op_i == MDU_DIVU) begin
            stall_o   = 1'b1;
            div_start = 1'b1;
            neg_quo_d = div_signed & (a_i[31] ^ b_i[31]);
            neg_rem_d = div_signed & a_i[31];
            state_d   = DIV;
          end
        end
      end
      MUL: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = mul_result;
          done_d       = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DIV: begin
        stall_o = 1'b1;
        if (flush_i) begin
          div_abort = 1'b1;
          state_d   = IDLE;
        end else if (!div_busy) begin
          lo_d    = neg_quo_q ? (~div_quo + 32'd1) : div_quo;
          hi_d    = neg_rem_q ? (~div_rem + 32'd1) : div_rem;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= MDU_NONE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
